// File: rtl/quiz_pkg.sv
// Shared types, legacy key table and width helper for the quiz answer checker.
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ANS = 2'd1,
    FEEDBACK = 2'd2,
    DONE     = 2'd3
  } stateT;

  // Rows are patterns 0..3, entries are rounds 0..3.
  localparam logic [1:0] LEGACY_KEY [4][4] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd2, 2'd3, 2'd0, 2'd1},
    '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd2, 2'd1, 2'd3}
  };

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/answer_round_checker_if.sv
// Player-side answer handshake and game status bus of the round checker.
interface answer_round_checker_if #(
  parameter int unsigned ANS_W   = 2,
  parameter int unsigned PAT_W   = 2,
  parameter int unsigned RND_W   = 2,
  parameter int unsigned SCORE_W = 3
);
  logic               start;
  logic [PAT_W-1:0]   pattern;
  logic               ans_valid;
  logic [ANS_W-1:0]   ans;
  logic               ans_ready;
  logic [RND_W-1:0]   round;
  logic               correct_pulse;
  logic               wrong_pulse;
  logic               timeout_pulse;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;

  modport master (
    output start, pattern, ans_valid, ans,
    input  ans_ready, round, correct_pulse, wrong_pulse, timeout_pulse, score, busy, done
  );

  modport slave (
    input  start, pattern, ans_valid, ans,
    output ans_ready, round, correct_pulse, wrong_pulse, timeout_pulse, score, busy, done
  );
endinterface

// File: rtl/answer_key.sv
// Combinational answer key for (pattern, round); legacy table where it applies.
module answer_key
  import quiz_pkg::*;
#(
  parameter int unsigned ANS_W = 2,
  parameter int unsigned PAT_W = 2,
  parameter int unsigned RND_W = 2
) (
  input  logic [PAT_W-1:0] pattern,
  input  logic [RND_W-1:0] round,
  output logic [ANS_W-1:0] key_c
);

  always_comb begin
    key_c = ANS_W'(32'd5 * 32'(pattern) + 32'd3 * 32'(round) + 32'd1);
    if (ANS_W == 2 && 32'(pattern) < 32'd4 && 32'(round) < 32'd4)
      key_c = ANS_W'(LEGACY_KEY[2'(pattern)][2'(round)]);
  end

endmodule

// File: rtl/answer_round_checker.sv
// Runs one quiz game of NUM_ROUNDS questions: per-round answer compare, timeout, scoring.
module answer_round_checker
  import quiz_pkg::*;
#(
  parameter int unsigned ANS_W       = 2,
  parameter int unsigned PAT_W       = 2,
  parameter int unsigned NUM_ROUNDS  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic clk,
  input logic reset,
  answer_round_checker_if.slave bus
);

  localparam int unsigned RND_W    = (clog2(NUM_ROUNDS) < 1) ? 1 : clog2(NUM_ROUNDS);
  localparam int unsigned SCORE_W  = clog2(NUM_ROUNDS + 1);
  localparam int unsigned TIM_W    = (clog2(TIMEOUT_CYC) < 1) ? 1 : clog2(TIMEOUT_CYC);
  localparam int unsigned TIM_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam int unsigned LAST_RND = NUM_ROUNDS - 1;

  stateT              state, stateD;
  logic [RND_W-1:0]   roundQ, roundD;
  logic [SCORE_W-1:0] scoreQ, scoreD;
  logic [TIM_W-1:0]   timer, timerD;
  logic [PAT_W-1:0]   patQ, patD;
  logic               readyQ, readyD;
  logic               busyQ, busyD;
  logic               correctQ, correctD;
  logic               wrongQ, wrongD;
  logic               timeoutQ, timeoutD;
  logic               doneQ, doneD;
  logic [ANS_W-1:0]   key;

  answer_key #(
    .ANS_W(ANS_W),
    .PAT_W(PAT_W),
    .RND_W(RND_W)
  ) keyGen (
    .pattern(patQ),
    .round  (roundQ),
    .key_c  (key)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      roundQ   <= '0;
      scoreQ   <= '0;
      timer    <= '0;
      patQ     <= '0;
      readyQ   <= 1'b0;
      busyQ    <= 1'b0;
      correctQ <= 1'b0;
      wrongQ   <= 1'b0;
      timeoutQ <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      state    <= stateD;
      roundQ   <= roundD;
      scoreQ   <= scoreD;
      timer    <= timerD;
      patQ     <= patD;
      readyQ   <= readyD;
      busyQ    <= busyD;
      correctQ <= correctD;
      wrongQ   <= wrongD;
      timeoutQ <= timeoutD;
      doneQ    <= doneD;
    end
  end

  // Next state; pulse values are computed one cycle ahead so they land in FEEDBACK/DONE.
  always_comb begin
    stateD   = state;
    roundD   = roundQ;
    scoreD   = scoreQ;
    timerD   = timer;
    patD     = patQ;
    correctD = 1'b0;
    wrongD   = 1'b0;
    timeoutD = 1'b0;
    doneD    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          patD   = bus.pattern;
          scoreD = '0;
          roundD = '0;
          timerD = '0;
          stateD = WAIT_ANS;
        end
      end
      WAIT_ANS: begin
        timerD = timer + TIM_W'(1);
        if (bus.ans_valid) begin
          stateD = FEEDBACK;
          if (bus.ans == key) begin
            correctD = 1'b1;
            scoreD   = scoreQ + SCORE_W'(1);
          end else begin
            wrongD = 1'b1;
          end
        end else if (TIMEOUT_CYC != 0 && timer == TIM_W'(TIM_LAST)) begin
          stateD   = FEEDBACK;
          wrongD   = 1'b1;
          timeoutD = 1'b1;
        end
      end
      FEEDBACK: begin
        timerD = '0;
        if (roundQ == RND_W'(LAST_RND)) begin
          stateD = DONE;
          doneD  = 1'b1;
        end else begin
          roundD = roundQ + RND_W'(1);
          stateD = WAIT_ANS;
        end
      end
      DONE: stateD = IDLE;
      default: stateD = IDLE;
    endcase
    readyD = (stateD == WAIT_ANS);
    busyD  = (stateD != IDLE);
  end

  assign bus.ans_ready     = readyQ;
  assign bus.round         = roundQ;
  assign bus.score         = scoreQ;
  assign bus.busy          = busyQ;
  assign bus.correct_pulse = correctQ;
  assign bus.wrong_pulse   = wrongQ;
  assign bus.timeout_pulse = timeoutQ;
  assign bus.done          = doneQ;

endmodule

// File: tb/tb_answer_round_checker.sv
// Bench for answer_round_checker: legacy 4-round config with short timeout and a 6-round 3-bit config.
module tb_answer_round_checker;

  logic       clk;
  logic       reset;
  logic       startS;
  logic [1:0] patS;
  logic       ansValid;
  logic [2:0] ansS;
  bit         sel;

  int checks = 0;
  int errors = 0;
  int dlyQ[$];
  int ansQ[$];
  int legacy [4][4] = '{'{1, 0, 3, 2}, '{2, 3, 0, 1}, '{3, 2, 1, 0}, '{0, 2, 1, 3}};

  answer_round_checker_if #(.ANS_W(2), .PAT_W(2), .RND_W(2), .SCORE_W(3)) busA ();
  answer_round_checker_if #(.ANS_W(3), .PAT_W(2), .RND_W(3), .SCORE_W(3)) busC ();

  answer_round_checker #(.ANS_W(2), .PAT_W(2), .NUM_ROUNDS(4), .TIMEOUT_CYC(10)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave));
  answer_round_checker #(.ANS_W(3), .PAT_W(2), .NUM_ROUNDS(6), .TIMEOUT_CYC(0)) dutC (
    .clk(clk), .reset(reset), .bus(busC.slave));

  assign busA.start     = startS & ~sel;
  assign busC.start     = startS & sel;
  assign busA.pattern   = patS;
  assign busC.pattern   = patS;
  assign busA.ans_valid = ansValid;
  assign busC.ans_valid = ansValid;
  assign busA.ans       = ansS[1:0];
  assign busC.ans       = ansS;

  // {ready, busy, correct, wrong, timeout, done, round[2:0], score[2:0]}
  logic [11:0] mon;
  always_comb begin
    if (sel)
      mon = {busC.ans_ready, busC.busy, busC.correct_pulse, busC.wrong_pulse,
             busC.timeout_pulse, busC.done, busC.round, busC.score};
    else
      mon = {busA.ans_ready, busA.busy, busA.correct_pulse, busA.wrong_pulse,
             busA.timeout_pulse, busA.done, 1'b0, busA.round, busA.score};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int keyOf(input int p, input int r, input int aw);
    if (aw == 2 && p < 4 && r < 4) return legacy[p][r];
    return (5 * p + 3 * r + 1) % (1 << aw);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays one game on the selected DUT from dlyQ/ansQ; a delay >= tmo (tmo>0) means no answer.
  task automatic runGame(input string tag, input int pat, input int nr, input int aw,
                         input int tmo, input int startRound, input int resetRound);
    int expScore;
    int d;
    int a;
    int waitLen;
    bit isTo;
    bit isOk;
    logic [11:0] exp;
    startS = 1'b1;
    patS   = 2'(pat);
    tick();
    startS = 1'b0;
    expScore = 0;
    for (int r = 0; r < nr; r++) begin
      if (r == resetRound) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (mon !== 12'd0) begin
            errors++;
            $display("FAIL %s reset_mid cyc%0d got %b want %b", tag, k, mon, 12'd0);
          end
          tick();
        end
        return;
      end
      d = dlyQ[r];
      a = ansQ[r];
      isTo = (tmo > 0) && (d >= tmo);
      waitLen = isTo ? tmo : d + 1;
      for (int t = 0; t < waitLen; t++) begin
        exp = {1'b1, 1'b1, 4'b0000, 3'(r), 3'(expScore)};
        checks++;
        if (mon !== exp) begin
          errors++;
          $display("FAIL %s wait r%0d t%0d got %b want %b", tag, r, t, mon, exp);
        end
        if (r == startRound && t == 0) begin
          startS = 1'b1;
          patS   = 2'd2;
        end else begin
          startS = 1'b0;
        end
        ansValid = (!isTo && t == d);
        ansS     = 3'(a);
        tick();
      end
      ansValid = 1'b0;
      startS   = 1'b0;
      isOk = !isTo && (a == keyOf(pat, r, aw));
      if (isOk) expScore++;
      exp = {1'b0, 1'b1, isOk, !isOk, isTo, 1'b0, 3'(r), 3'(expScore)};
      checks++;
      if (mon !== exp) begin
        errors++;
        $display("FAIL %s feedback r%0d got %b want %b", tag, r, mon, exp);
      end
      tick();
    end
    exp = {1'b0, 1'b1, 4'b0001, 3'(nr - 1), 3'(expScore)};
    checks++;
    if (mon !== exp) begin
      errors++;
      $display("FAIL %s done got %b want %b", tag, mon, exp);
    end
    tick();
    exp = {6'b000000, 3'(nr - 1), 3'(expScore)};
    checks++;
    if (mon !== exp) begin
      errors++;
      $display("FAIL %s idle_hold got %b want %b", tag, mon, exp);
    end
  endtask

  task automatic setGame(input int d0, input int d1, input int d2, input int d3,
                         input int a0, input int a1, input int a2, input int a3);
    dlyQ = '{d0, d1, d2, d3};
    ansQ = '{a0, a1, a2, a3};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    ansValid = 1'b1;
    ansS = 3'd1;
    tick();
    ansValid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      checks++;
      if (mon !== 12'd0) begin
        errors++;
        $display("FAIL reset sel%0d got %b want %b", s, mon, 12'd0);
      end
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_all_correct();
    sel = 1'b0;
    setGame(0, 0, 0, 0, 1, 0, 3, 2);
    runGame("all_correct", 0, 4, 2, 10, -1, -1);
  endtask

  task automatic test_mixed();
    sel = 1'b0;
    setGame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            0, 0, 1, 3);
    runGame("mixed", 3, 4, 2, 10, -1, -1);
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    setGame(100, 100, 100, 100, 0, 0, 0, 0);
    runGame("timeout", 1, 4, 2, 10, -1, -1);
  endtask

  task automatic test_answer_wins();
    sel = 1'b0;
    setGame(9, 9, 9, 9, 2, 3, 0, 1);
    runGame("answer_wins", 1, 4, 2, 10, -1, -1);
  endtask

  task automatic test_start_ignored();
    sel = 1'b0;
    setGame(1, 2, 3, 0, 2, 3, 0, 1);
    runGame("start_ignored", 1, 4, 2, 10, 2, -1);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    setGame(0, 1, 2, 0, 2, 3, 0, 1);
    runGame("reset_mid", 1, 4, 2, 10, -1, 2);
  endtask

  task automatic test_wide();
    sel = 1'b1;
    #1;
    dlyQ.delete();
    ansQ = '{3, 6, 1, 4, 7, 2};
    for (int r = 0; r < 6; r++) dlyQ.push_back($urandom_range(0, 20));
    runGame("wide", 2, 6, 3, 0, -1, -1);
    sel = 1'b0;
    #1;
  endtask

  task automatic test_random();
    int nr;
    int aw;
    int tmo;
    int pat;
    for (int g = 0; g < 20; g++) begin
      sel = bit'($urandom_range(0, 1));
      #1;
      nr  = sel ? 6 : 4;
      aw  = sel ? 3 : 2;
      tmo = sel ? 0 : 10;
      pat = $urandom_range(0, 3);
      dlyQ.delete();
      ansQ.delete();
      for (int r = 0; r < nr; r++) begin
        dlyQ.push_back(sel ? $urandom_range(0, 25) : $urandom_range(0, 13));
        if ($urandom_range(0, 1) == 1) ansQ.push_back(keyOf(pat, r, aw));
        else ansQ.push_back($urandom_range(0, (1 << aw) - 1));
      end
      runGame("random", pat, nr, aw, tmo, -1, -1);
      tick();
    end
    sel = 1'b0;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    startS   = 1'b0;
    patS     = 2'd0;
    ansValid = 1'b0;
    ansS     = 3'd0;
    sel      = 1'b0;
    test_reset();
    test_all_correct();
    test_mixed();
    test_timeout();
    test_answer_wins();
    test_start_ignored();
    test_reset_mid();
    test_wide();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
